// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronises the
// active-low column lines, debounces press and release, and emits one key
// code pulse per debounced press.
module keypad_scanner #(
  parameter int unsigned ROW_CYCLES  = 10000,
  parameter int unsigned DEB_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TickW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int unsigned DebW  = $clog2(DEB_SAMPLES + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(ROW_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_SAMPLES);
  localparam logic [DebW-1:0]  DebOne  = DebW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       col_meta, col_sync;
  logic [TickW-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             any_low;
  logic [1:0]       hit_col;
  logic             sel_low;

  // Two-flop synchroniser for the asynchronous column lines (idle high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;
    end
  end

  // Free-running row-period counter; tick marks the sampling instant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TickW'(1);
    end
  end

  assign tick = (tick_cnt == TickMax);

  // Lowest-index low column wins when several keys share the scanned row.
  always_comb begin
    any_low = ~&col_sync;
    hit_col = 2'd0;
    if (!col_sync[0])      hit_col = 2'd0;
    else if (!col_sync[1]) hit_col = 2'd1;
    else if (!col_sync[2]) hit_col = 2'd2;
    else                   hit_col = 2'd3;
    sel_low = ~col_sync[col_q];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StScan;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      deb_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; every transition is gated by tick.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (any_low) begin
            col_d = hit_col;
            deb_d = DebOne;
            if (DebMax == DebOne) begin
              code_d  = {row_q, hit_col};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = StPressed;
            end else begin
              state_d = StDebounce;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        StDebounce: begin
          if (sel_low) begin
            deb_d = deb_q + DebOne;
            if (deb_q + DebOne == DebMax) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = StPressed;
            end
          end else begin
            row_d   = row_q + 2'd1;
            state_d = StScan;
          end
        end
        StPressed: begin
          if (!sel_low) begin
            deb_d = DebOne;
            if (DebMax == DebOne) begin
              held_d  = 1'b0;
              row_d   = row_q + 2'd1;
              state_d = StScan;
            end else begin
              state_d = StRelease;
            end
          end
        end
        StRelease: begin
          if (!sel_low) begin
            deb_d = deb_q + DebOne;
            if (deb_q + DebOne == DebMax) begin
              held_d  = 1'b0;
              row_d   = row_q + 2'd1;
              state_d = StScan;
            end
          end else begin
            // Rebound: the key is still down, no new pulse.
            state_d = StPressed;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Active-low one-hot row drive and registered outputs.
  always_comb begin
    key_row   = ~(4'b0001 << row_q);
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = held_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model that
// pulls a column low when its key is pressed and its row is driven.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;  // bit r*4+c = key at row r, column c is pressed
  int          n_vec;
  int          n_err;
  int          vcount;

  keypad_scanner #(
    .ROW_CYCLES (4),
    .DEB_SAMPLES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_col  (key_col),
    .key_row  (key_row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
      end
    end
  end

  // Count key_valid pulses.
  always @(negedge clk) begin
    if (key_valid) vcount <= vcount + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    vcount = 0;
    keys   = 16'h0;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row", 32'(key_row), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    rst = 1'b1;

    // Idle scanning.
    step(4);  check("scan_r1", 32'(key_row), 32'hD);
    step(4);  check("scan_r2", 32'(key_row), 32'hB);
    step(4);  check("scan_r3", 32'(key_row), 32'h7);
    step(4);  check("scan_r0", 32'(key_row), 32'hE);
    check("scan_nopulse", 32'(vcount), 32'd0);

    // Hold row2/col1.
    keys[9] = 1'b1;
    step(20);
    check("hold_valid", 32'(key_valid), 32'h1);
    check("hold_code", 32'(key_code), 32'h9);
    check("hold_held", 32'(key_held), 32'h1);
    check("hold_row", 32'(key_row), 32'hB);
    step(1);
    check("hold_pulse_end", 32'(key_valid), 32'h0);
    step(19);
    check("hold_row_frozen", 32'(key_row), 32'hB);
    check("hold_held2", 32'(key_held), 32'h1);
    check("hold_one_pulse", 32'(vcount), 32'd1);

    // Release with a one-tick rebound.
    keys[9] = 1'b0;
    step(4);  check("rel_held_a", 32'(key_held), 32'h1);
    keys[9] = 1'b1;
    step(4);  check("rel_held_b", 32'(key_held), 32'h1);
    keys[9] = 1'b0;
    step(8);  check("rel_held_c", 32'(key_held), 32'h1);
    step(4);
    check("rel_held_done", 32'(key_held), 32'h0);
    check("rel_row", 32'(key_row), 32'h7);
    check("rel_code_kept", 32'(key_code), 32'h9);
    check("rel_no_pulse", 32'(vcount), 32'd1);

    // One-tick glitch on row1/col3.
    step(8);  check("glitch_r1", 32'(key_row), 32'hD);
    keys[7] = 1'b1;
    step(4);  check("glitch_frozen", 32'(key_row), 32'hD);
    keys[7] = 1'b0;
    step(4);
    check("glitch_resume", 32'(key_row), 32'hB);
    check("glitch_no_pulse", 32'(vcount), 32'd1);
    check("glitch_held", 32'(key_held), 32'h0);

    // Two keys on row 0: lowest column wins; later key on row 3 ignored.
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    step(20);
    check("multi_valid", 32'(key_valid), 32'h1);
    check("multi_code", 32'(key_code), 32'h0);
    check("multi_held", 32'(key_held), 32'h1);
    keys[15] = 1'b1;
    step(16);
    check("ignore_row", 32'(key_row), 32'hE);
    check("ignore_count", 32'(vcount), 32'd2);
    check("ignore_code", 32'(key_code), 32'h0);

    // Release, then enter DEBOUNCE on row1/col0 and reset there.
    keys = 16'h0;
    keys[4] = 1'b1;
    step(16);
    check("deb_row", 32'(key_row), 32'hD);
    check("deb_held", 32'(key_held), 32'h0);
    step(4);
    rst = 1'b0;
    #1;
    check("async_row", 32'(key_row), 32'hE);
    check("async_valid", 32'(key_valid), 32'h0);
    check("async_held", 32'(key_held), 32'h0);
    check("async_code", 32'(key_code), 32'h0);
    keys = 16'h0;
    @(negedge clk);
    rst = 1'b1;
    step(24);
    check("post_rst_row", 32'(key_row), 32'hB);
    check("post_rst_count", 32'(vcount), 32'd2);
    check("post_rst_held", 32'(key_held), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
